// File: rtl/wb_exc_commit_pkg.sv
// Shared writeback-stage definitions: CSR index width, exception codes,
// subcodes, exception flag bit positions and the WB state encoding.
package wb_exc_commit_pkg;

    localparam int WIDTH_CSR_NUM = 14;

    // Exception codes reported to the CSR file
    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;

    // ADE splits into fetch-side and memory-side faults
    localparam logic [8:0] ESUBCODE_ADEF = 9'd0;
    localparam logic [8:0] ESUBCODE_ADEM = 9'd1;

    // Bit positions inside the exception flag vector carried from MEM
    localparam int EXC_VEC_ADEF = 0;
    localparam int EXC_VEC_INE  = 1;
    localparam int EXC_VEC_SYS  = 2;
    localparam int EXC_VEC_BRK  = 3;
    localparam int EXC_VEC_ALE  = 4;
    localparam int EXC_VEC_ADEM = 5;
    localparam int EXC_VEC_W    = 6;

    typedef enum logic [0:0] {
        WS_NORMAL = 1'b0,
        WS_FLUSH  = 1'b1
    } ws_state_t;

endpackage

// File: rtl/wb_exc_commit_exc_prio_enc.sv
// Exception priority encoder: INT > ADEF > INE > SYS > BRK > ALE > ADEM.
// use_vaddr marks the data-address faults whose bad address is the
// memory address rather than the instruction PC.
module exc_prio_enc
    import wb_exc_commit_pkg::*;
(
    input  logic [EXC_VEC_W-1:0] exc_vec,
    input  logic                 int_tag,
    output logic                 exc,
    output logic [5:0]           ecode,
    output logic [8:0]           esubcode,
    output logic                 use_vaddr
);

    // Select the highest-priority pending cause
    always_comb begin
        exc       = int_tag || (|exc_vec);
        ecode     = ECODE_INT;
        esubcode  = ESUBCODE_ADEF;
        use_vaddr = 1'b0;
        if (int_tag) begin
            ecode = ECODE_INT;
        end else if (exc_vec[EXC_VEC_ADEF]) begin
            ecode    = ECODE_ADE;
            esubcode = ESUBCODE_ADEF;
        end else if (exc_vec[EXC_VEC_INE]) begin
            ecode = ECODE_INE;
        end else if (exc_vec[EXC_VEC_SYS]) begin
            ecode = ECODE_SYS;
        end else if (exc_vec[EXC_VEC_BRK]) begin
            ecode = ECODE_BRK;
        end else if (exc_vec[EXC_VEC_ALE]) begin
            ecode     = ECODE_ALE;
            use_vaddr = 1'b1;
        end else if (exc_vec[EXC_VEC_ADEM]) begin
            ecode     = ECODE_ADE;
            esubcode  = ESUBCODE_ADEM;
            use_vaddr = 1'b1;
        end
    end

endmodule

// File: rtl/wb_exc_commit.sv
// Writeback commit and exception arbitration. Holds the WB register for
// one cycle per instruction, raises exception / ERTN / CSR / GPR strobes
// and, on an exceptional or ERTN commit, flushes the pipeline and holds a
// fetch redirect until fetch accepts it.
// Optional golden-trace outputs are enabled with WB_DEBUG_TRACE_EN.
module wb_exc_commit
    import wb_exc_commit_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ms_valid,
    output logic                     ws_allowin,
    input  logic [31:0]              ms_pc,
    input  logic [EXC_VEC_W-1:0]     ms_exc_vec,
    input  logic [31:0]              ms_vaddr,
    input  logic                     ms_ertn,
    input  logic                     ms_csr_we,
    input  logic [WIDTH_CSR_NUM-1:0] ms_csr_num,
    input  logic [31:0]              ms_csr_wmask,
    input  logic [31:0]              ms_csr_wvalue,
    input  logic                     ms_rf_we,
    input  logic [4:0]               ms_rf_waddr,
    input  logic [31:0]              ms_rf_wdata,
    input  logic                     has_int,
    input  logic [31:0]              ex_entry,
    input  logic [31:0]              ertn_pc,
    output logic                     wb_ex,
    output logic [31:0]              wb_pc,
    output logic [5:0]               wb_ecode,
    output logic [8:0]               wb_esubcode,
    output logic [31:0]              wb_vaddr,
    output logic                     ertn_flush,
    output logic                     csr_we,
    output logic [WIDTH_CSR_NUM-1:0] csr_num,
    output logic [31:0]              csr_wmask,
    output logic [31:0]              csr_wvalue,
    output logic                     rf_we,
    output logic [4:0]               rf_waddr,
    output logic [31:0]              rf_wdata,
    output logic                     ws_flush,
    output logic                     flush_valid,
    output logic [31:0]              flush_pc,
    input  logic                     flush_ready
`ifdef WB_DEBUG_TRACE_EN
    ,
    output logic [31:0]              debug_wb_pc,
    output logic [3:0]               debug_wb_rf_we,
    output logic [4:0]               debug_wb_rf_wnum,
    output logic [31:0]              debug_wb_rf_wdata
`endif
);

    ws_state_t                state_reg, state_next;
    logic                     ws_valid_reg;
    logic [31:0]              ws_pc_reg;
    logic [EXC_VEC_W-1:0]     ws_exc_vec_reg;
    logic [31:0]              ws_vaddr_reg;
    logic                     ws_ertn_reg;
    logic                     ws_csr_we_reg;
    logic [WIDTH_CSR_NUM-1:0] ws_csr_num_reg;
    logic [31:0]              ws_csr_wmask_reg;
    logic [31:0]              ws_csr_wvalue_reg;
    logic                     ws_rf_we_reg;
    logic [4:0]               ws_rf_waddr_reg;
    logic [31:0]              ws_rf_wdata_reg;
    logic [31:0]              flush_pc_reg;

    logic       commit;
    logic       redirect;
    logic       load;
    logic       exc;
    logic       use_vaddr;
    logic [5:0] ecode;
    logic [8:0] esubcode;

    // A WB instruction only commits while no redirect is outstanding
    assign commit   = ws_valid_reg && (state_reg == WS_NORMAL);
    assign redirect = commit && (exc || ws_ertn_reg);
    assign load     = ms_valid && ws_allowin && (state_reg == WS_NORMAL) && !ws_flush;

    // Interrupts are only meaningful against a committing instruction
    exc_prio_enc u_prio_enc (
        .exc_vec   (ws_exc_vec_reg),
        .int_tag   (has_int && commit),
        .exc       (exc),
        .ecode     (ecode),
        .esubcode  (esubcode),
        .use_vaddr (use_vaddr)
    );

    // WB pipeline register: one cycle per instruction, dropped while flushing
    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid_reg      <= 1'b0;
            ws_pc_reg         <= '0;
            ws_exc_vec_reg    <= '0;
            ws_vaddr_reg      <= '0;
            ws_ertn_reg       <= 1'b0;
            ws_csr_we_reg     <= 1'b0;
            ws_csr_num_reg    <= '0;
            ws_csr_wmask_reg  <= '0;
            ws_csr_wvalue_reg <= '0;
            ws_rf_we_reg      <= 1'b0;
            ws_rf_waddr_reg   <= '0;
            ws_rf_wdata_reg   <= '0;
        end else begin
            ws_valid_reg <= load;
            if (load) begin
                ws_pc_reg         <= ms_pc;
                ws_exc_vec_reg    <= ms_exc_vec;
                ws_vaddr_reg      <= ms_vaddr;
                ws_ertn_reg       <= ms_ertn;
                ws_csr_we_reg     <= ms_csr_we;
                ws_csr_num_reg    <= ms_csr_num;
                ws_csr_wmask_reg  <= ms_csr_wmask;
                ws_csr_wvalue_reg <= ms_csr_wvalue;
                ws_rf_we_reg      <= ms_rf_we;
                ws_rf_waddr_reg   <= ms_rf_waddr;
                ws_rf_wdata_reg   <= ms_rf_wdata;
            end
        end
    end

    // State register plus the redirect target captured at commit
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= WS_NORMAL;
            flush_pc_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (redirect) begin
                flush_pc_reg <= exc ? ex_entry : ertn_pc;
            end
        end
    end

    // Next state: enter FLUSH on a redirecting commit, leave on handshake
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            WS_NORMAL: if (redirect)    state_next = WS_FLUSH;
            WS_FLUSH:  if (flush_ready) state_next = WS_NORMAL;
            default:                    state_next = WS_NORMAL;
        endcase
    end

    // Outputs: strobes gated by commit, flush controls from state
    always_comb begin
        ws_allowin  = 1'b1;
        wb_ex       = commit && exc;
        ertn_flush  = commit && !exc && ws_ertn_reg;
        csr_we      = commit && !exc && ws_csr_we_reg;
        rf_we       = commit && !exc && ws_rf_we_reg;
        ws_flush    = redirect || (state_reg == WS_FLUSH);
        flush_valid = (state_reg == WS_FLUSH);
    end

    assign wb_pc       = ws_pc_reg;
    assign wb_ecode    = ecode;
    assign wb_esubcode = esubcode;
    assign wb_vaddr    = use_vaddr ? ws_vaddr_reg : ws_pc_reg;
    assign csr_num     = ws_csr_num_reg;
    assign csr_wmask   = ws_csr_wmask_reg;
    assign csr_wvalue  = ws_csr_wvalue_reg;
    assign rf_waddr    = ws_rf_waddr_reg;
    assign rf_wdata    = ws_rf_wdata_reg;
    assign flush_pc    = flush_pc_reg;

`ifdef WB_DEBUG_TRACE_EN
    assign debug_wb_pc       = ws_pc_reg;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = ws_rf_waddr_reg;
    assign debug_wb_rf_wdata = ws_rf_wdata_reg;
`endif

endmodule

// File: tb/tb_wb_exc_commit.sv
// Self-checking bench for wb_exc_commit: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_wb_exc_commit;
    import wb_exc_commit_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     reset;
    logic                     ms_valid;
    logic                     ws_allowin;
    logic [31:0]              ms_pc;
    logic [5:0]               ms_exc_vec;
    logic [31:0]              ms_vaddr;
    logic                     ms_ertn;
    logic                     ms_csr_we;
    logic [WIDTH_CSR_NUM-1:0] ms_csr_num;
    logic [31:0]              ms_csr_wmask;
    logic [31:0]              ms_csr_wvalue;
    logic                     ms_rf_we;
    logic [4:0]               ms_rf_waddr;
    logic [31:0]              ms_rf_wdata;
    logic                     has_int;
    logic [31:0]              ex_entry;
    logic [31:0]              ertn_pc;
    logic                     wb_ex;
    logic [31:0]              wb_pc;
    logic [5:0]               wb_ecode;
    logic [8:0]               wb_esubcode;
    logic [31:0]              wb_vaddr;
    logic                     ertn_flush;
    logic                     csr_we;
    logic [WIDTH_CSR_NUM-1:0] csr_num;
    logic [31:0]              csr_wmask;
    logic [31:0]              csr_wvalue;
    logic                     rf_we;
    logic [4:0]               rf_waddr;
    logic [31:0]              rf_wdata;
    logic                     ws_flush;
    logic                     flush_valid;
    logic [31:0]              flush_pc;
    logic                     flush_ready;
`ifdef WB_DEBUG_TRACE_EN
    logic [31:0]              debug_wb_pc;
    logic [3:0]               debug_wb_rf_we;
    logic [4:0]               debug_wb_rf_wnum;
    logic [31:0]              debug_wb_rf_wdata;
`endif

    wb_exc_commit dut (
        .clk           (clk),
        .reset         (reset),
        .ms_valid      (ms_valid),
        .ws_allowin    (ws_allowin),
        .ms_pc         (ms_pc),
        .ms_exc_vec    (ms_exc_vec),
        .ms_vaddr      (ms_vaddr),
        .ms_ertn       (ms_ertn),
        .ms_csr_we     (ms_csr_we),
        .ms_csr_num    (ms_csr_num),
        .ms_csr_wmask  (ms_csr_wmask),
        .ms_csr_wvalue (ms_csr_wvalue),
        .ms_rf_we      (ms_rf_we),
        .ms_rf_waddr   (ms_rf_waddr),
        .ms_rf_wdata   (ms_rf_wdata),
        .has_int       (has_int),
        .ex_entry      (ex_entry),
        .ertn_pc       (ertn_pc),
        .wb_ex         (wb_ex),
        .wb_pc         (wb_pc),
        .wb_ecode      (wb_ecode),
        .wb_esubcode   (wb_esubcode),
        .wb_vaddr      (wb_vaddr),
        .ertn_flush    (ertn_flush),
        .csr_we        (csr_we),
        .csr_num       (csr_num),
        .csr_wmask     (csr_wmask),
        .csr_wvalue    (csr_wvalue),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .ws_flush      (ws_flush),
        .flush_valid   (flush_valid),
        .flush_pc      (flush_pc),
        .flush_ready   (flush_ready)
`ifdef WB_DEBUG_TRACE_EN
        ,
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // Instruction as seen by the model
    typedef struct {
        logic [31:0]              pc;
        logic [5:0]               ev;
        logic [31:0]              vaddr;
        logic                     ertn;
        logic                     csr_we;
        logic [WIDTH_CSR_NUM-1:0] csr_num;
        logic [31:0]              csr_wmask;
        logic [31:0]              csr_wvalue;
        logic                     rf_we;
        logic [4:0]               rf_waddr;
        logic [31:0]              rf_wdata;
    } instr_t;

    // Model: an instruction waiting in WB, and an outstanding redirect
    bit          m_valid;
    bit          m_pend;
    instr_t      m_wb;
    logic [31:0] m_fpc;
    bit          s_redirect;
    bit          s_exc;

    // Cause table in priority order, indexed by flag bit (INT handled apart)
    int prio_code [6] = '{8, 13, 11, 12, 9, 8};
    int prio_sub  [6] = '{0, 0, 0, 0, 0, 1};
    bit prio_va   [6] = '{0, 0, 0, 0, 1, 1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_idle();
        ms_valid      = 0;
        ms_pc         = 32'h0;
        ms_exc_vec    = 6'h0;
        ms_vaddr      = 32'h0;
        ms_ertn       = 0;
        ms_csr_we     = 0;
        ms_csr_num    = '0;
        ms_csr_wmask  = 32'h0;
        ms_csr_wvalue = 32'h0;
        ms_rf_we      = 0;
        ms_rf_waddr   = 5'h0;
        ms_rf_wdata   = 32'h0;
        has_int       = 0;
        ex_entry      = 32'h0;
        ertn_pc       = 32'h0;
        flush_ready   = 1;
    endtask

    // Compare every output against the model for the current cycle
    task automatic settle_and_check();
        bit       commit, exc, usev, e_rf, e_csr, e_ertn;
        int       code, sub;
        #2;
        commit = m_valid && !m_pend;
        exc = 0; usev = 0; code = 0; sub = 0;
        if (commit) begin
            if (has_int) begin
                exc = 1;
            end else begin
                for (int i = 0; i < 6; i++) begin
                    if (!exc && m_wb.ev[i]) begin
                        exc  = 1;
                        code = prio_code[i];
                        sub  = prio_sub[i];
                        usev = prio_va[i];
                    end
                end
            end
        end
        e_ertn = commit && !exc && m_wb.ertn;
        e_csr  = commit && !exc && m_wb.csr_we;
        e_rf   = commit && !exc && m_wb.rf_we;
        check("allowin", ws_allowin, 1);
        check("wb_ex", wb_ex, commit && exc);
        check("ertn_flush", ertn_flush, e_ertn);
        check("csr_we", csr_we, e_csr);
        check("rf_we", rf_we, e_rf);
        check("ws_flush", ws_flush, (commit && (exc || m_wb.ertn)) || m_pend);
        check("flush_valid", flush_valid, m_pend);
        check("flush_pc", flush_pc, m_fpc);
        if (commit) begin
            check("wb_pc", wb_pc, m_wb.pc);
            if (exc) begin
                check("ecode", wb_ecode, code);
                check("esubcode", wb_esubcode, sub);
                check("wb_vaddr", wb_vaddr, usev ? m_wb.vaddr : m_wb.pc);
            end
            if (e_rf) begin
                check("rf_waddr", rf_waddr, m_wb.rf_waddr);
                check("rf_wdata", rf_wdata, m_wb.rf_wdata);
            end
            if (e_csr) begin
                check("csr_num", csr_num, m_wb.csr_num);
                check("csr_wmask", csr_wmask, m_wb.csr_wmask);
                check("csr_wvalue", csr_wvalue, m_wb.csr_wvalue);
            end
`ifdef WB_DEBUG_TRACE_EN
            check("dbg_pc", debug_wb_pc, m_wb.pc);
`endif
            $display("commit pc=%08h ex=%0d ecode=%0h ertn=%0d rf_we=%0d csr_we=%0d",
                     m_wb.pc, exc, code, e_ertn, e_rf, e_csr);
        end
`ifdef WB_DEBUG_TRACE_EN
        check("dbg_rf_we", debug_wb_rf_we, {4{e_rf}});
`endif
        s_redirect = commit && (exc || m_wb.ertn);
        s_exc      = exc;
    endtask

    // Advance the model by one clock, then step the DUT
    task automatic advance();
        if (reset) begin
            m_valid = 0;
            m_pend  = 0;
            m_fpc   = 32'h0;
        end else if (m_pend) begin
            if (flush_ready) m_pend = 0;
            m_valid = 0;
        end else if (s_redirect) begin
            m_pend  = 1;
            m_fpc   = s_exc ? ex_entry : ertn_pc;
            m_valid = 0;
        end else begin
            m_valid          = ms_valid;
            m_wb.pc          = ms_pc;
            m_wb.ev          = ms_exc_vec;
            m_wb.vaddr       = ms_vaddr;
            m_wb.ertn        = ms_ertn;
            m_wb.csr_we      = ms_csr_we;
            m_wb.csr_num     = ms_csr_num;
            m_wb.csr_wmask   = ms_csr_wmask;
            m_wb.csr_wvalue  = ms_csr_wvalue;
            m_wb.rf_we       = ms_rf_we;
            m_wb.rf_waddr    = ms_rf_waddr;
            m_wb.rf_wdata    = ms_rf_wdata;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        settle_and_check();
        advance();
    endtask

    task automatic randomize_inputs();
        int r;
        ms_valid      = ($urandom_range(0, 9) < 7);
        ms_pc         = {$urandom_range(0, 32'hFFFF), 14'h0, 2'b00} | 32'h1c000000;
        r = $urandom_range(0, 9);
        if (r < 6)      ms_exc_vec = 6'h0;
        else if (r < 8) ms_exc_vec = 6'(1 << $urandom_range(0, 5));
        else            ms_exc_vec = 6'($urandom);
        ms_vaddr      = $urandom;
        ms_ertn       = ($urandom_range(0, 9) < 2);
        ms_csr_we     = $urandom_range(0, 1);
        ms_csr_num    = WIDTH_CSR_NUM'($urandom);
        ms_csr_wmask  = $urandom;
        ms_csr_wvalue = $urandom;
        ms_rf_we      = $urandom_range(0, 1);
        ms_rf_waddr   = 5'($urandom);
        ms_rf_wdata   = $urandom;
        has_int       = ($urandom_range(0, 9) == 0);
        ex_entry      = $urandom;
        ertn_pc       = $urandom;
        flush_ready   = $urandom_range(0, 1);
        reset         = ($urandom_range(0, 99) == 0);
    endtask

    initial begin
        set_idle();
        reset   = 1;
        m_valid = 0;
        m_pend  = 0;
        m_fpc   = 32'h0;
        m_wb    = '{default: '0};
        repeat (2) @(posedge clk);
        #1;
        reset = 0;

        // Reset state
        settle_and_check();
        check("rst_flush_valid", flush_valid, 0);
        check("rst_flush_pc", flush_pc, 0);
        check("rst_ws_flush", ws_flush, 0);
        advance();

        // Plain ADD
        ms_valid = 1; ms_pc = 32'h1c000000; ms_rf_we = 1; ms_rf_waddr = 5; ms_rf_wdata = 32'h1234;
        cycle();
        set_idle();
        settle_and_check();
        check("add_rf_we", rf_we, 1);
        check("add_waddr", rf_waddr, 5);
        check("add_wdata", rf_wdata, 32'h1234);
        check("add_wb_ex", wb_ex, 0);
        check("add_flush", ws_flush, 0);
        advance();

        // SYSCALL, redirect held while fetch stalls
        ms_valid = 1; ms_pc = 32'h1c000100; ms_exc_vec = 6'b000100; ms_rf_we = 1;
        cycle();
        set_idle();
        ex_entry = 32'h1c008000;
        settle_and_check();
        check("sys_wb_ex", wb_ex, 1);
        check("sys_ecode", wb_ecode, 6'hB);
        check("sys_rf_we", rf_we, 0);
        advance();
        ex_entry = 32'h0;
        flush_ready = 0;
        repeat (3) begin
            settle_and_check();
            check("sys_fv", flush_valid, 1);
            check("sys_fpc", flush_pc, 32'h1c008000);
            advance();
        end
        flush_ready = 1;
        cycle();
        cycle();

        // ALE with INE also set, then ALE alone
        ms_valid = 1; ms_pc = 32'h1c000300; ms_exc_vec = 6'b010010; ms_vaddr = 32'h80000003;
        cycle();
        set_idle();
        settle_and_check();
        check("aleine_ecode", wb_ecode, 6'hD);
        check("aleine_vaddr", wb_vaddr, 32'h1c000300);
        advance();
        cycle();
        ms_valid = 1; ms_pc = 32'h1c000304; ms_exc_vec = 6'b010000; ms_vaddr = 32'h80000003;
        cycle();
        set_idle();
        settle_and_check();
        check("ale_ecode", wb_ecode, 6'h9);
        check("ale_vaddr", wb_vaddr, 32'h80000003);
        advance();
        cycle();

        // ERTN, younger instructions offered during FLUSH are dropped
        ms_valid = 1; ms_pc = 32'h1c000400; ms_ertn = 1;
        cycle();
        set_idle();
        ertn_pc = 32'h1c000200;
        settle_and_check();
        check("ertn_flush", ertn_flush, 1);
        check("ertn_wb_ex", wb_ex, 0);
        advance();
        set_idle();
        ms_valid = 1; ms_rf_we = 1; ms_rf_waddr = 7; flush_ready = 0;
        settle_and_check();
        check("ertn_fpc", flush_pc, 32'h1c000200);
        advance();
        flush_ready = 1;
        cycle();
        set_idle();
        settle_and_check();
        check("ertn_drop_rf_we", rf_we, 0);
        advance();

        // Interrupt on a CSRWR commit
        ms_valid = 1; ms_pc = 32'h1c000500; ms_csr_we = 1; ms_csr_num = 14'h6;
        cycle();
        set_idle();
        has_int = 1;
        settle_and_check();
        check("int_wb_ex", wb_ex, 1);
        check("int_ecode", wb_ecode, 0);
        check("int_csr_we", csr_we, 0);
        check("int_wb_pc", wb_pc, 32'h1c000500);
        advance();
        set_idle();
        cycle();

        // Reset in the second FLUSH cycle abandons the redirect
        ms_valid = 1; ms_pc = 32'h1c000600; ms_exc_vec = 6'b001000;
        cycle();
        set_idle();
        ex_entry = 32'h1c00c000; flush_ready = 0;
        cycle();
        ex_entry = 32'h0;
        reset = 1;
        cycle();
        reset = 0;
        ms_valid = 1; ms_pc = 32'h1c000700; ms_rf_we = 1; ms_rf_waddr = 3; ms_rf_wdata = 32'hbeef;
        settle_and_check();
        check("rstf_fv", flush_valid, 0);
        advance();
        set_idle();
        settle_and_check();
        check("rstf_rf_we", rf_we, 1);
        check("rstf_wdata", rf_wdata, 32'hbeef);
        advance();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            randomize_inputs();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_exc_commit.md
# wb_exc_commit

Writeback-stage commit and exception arbitration unit. Holds the WB pipeline register, priority-encodes exception flags arriving from MEM (plus sampled interrupts), and drives the exception, ERTN and CSR-write strobes consumed by the CSR file. On any exceptional or ERTN commit it flushes the pipeline and issues a fetch redirect to the exception entry or the ERTN return PC, holding it until fetch accepts.

## Interface
Parameters: none. Widths come from the shared header.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- ms_valid  in  1  MEM stage holds a valid instruction
- ws_allowin  out  1  WB register can accept this cycle
- ms_pc  in  32  instruction PC
- ms_exc_vec  in  6  exception flags: [0] ADEF, [1] INE, [2] SYS, [3] BRK, [4] ALE, [5] ADEM
- ms_vaddr  in  32  faulting data address (ALE/ADEM)
- ms_ertn  in  1  instruction is ERTN
- ms_csr_we  in  1  CSR write request
- ms_csr_num  in  WIDTH_CSR_NUM  CSR index
- ms_csr_wmask  in  32  CSR write mask
- ms_csr_wvalue  in  32  CSR write data
- ms_rf_we  in  1  GPR write enable
- ms_rf_waddr  in  5  GPR index
- ms_rf_wdata  in  32  GPR data
- has_int  in  1  pending enabled interrupt from the CSR file
- ex_entry  in  32  exception entry address
- ertn_pc  in  32  ERA value
- wb_ex  out  1  exception commit strobe
- wb_pc  out  32  PC of the WB instruction
- wb_ecode  out  6  exception code
- wb_esubcode  out  9  exception subcode
- wb_vaddr  out  32  bad address
- ertn_flush  out  1  ERTN commit strobe
- csr_we  out  1  CSR write strobe
- csr_num  out  WIDTH_CSR_NUM  CSR index
- csr_wmask  out  32  CSR write mask
- csr_wvalue  out  32  CSR write data
- rf_we  out  1  GPR write strobe
- rf_waddr  out  5  GPR index
- rf_wdata  out  32  GPR data
- ws_flush  out  1  kill all younger instructions in IF/ID/EX/MEM
- flush_valid  out  1  redirect request to fetch
- flush_pc  out  32  redirect target
- flush_ready  in  1  fetch accepts the redirect

## Operation
- States: NORMAL, FLUSH. Reset → NORMAL.
- Load: when ms_valid && ws_allowin && state==NORMAL && !ws_flush, capture all ms_* fields and set ws_valid. Otherwise ws_valid clears. Every instruction spends exactly one cycle in WB.
- ws_allowin = 1 always, since WB never stalls. Data offered while ws_flush is high is dropped.
- Commit cycle, when ws_valid=1 in NORMAL:
  - int_tag = has_int sampled this cycle.
  - Priority, high to low: INT (0x0) > ADEF (0x8, sub 0) > INE (0xD) > SYS (0xB) > BRK (0xC) > ALE (0x9) > ADEM (0x8, sub 1).
  - exc = int_tag || |ws_exc_vec. This drives wb_ex, wb_ecode and wb_esubcode.
  - wb_vaddr = ws_vaddr for ALE/ADEM, otherwise ws_pc.
  - If exc: rf_we, csr_we and ertn_flush are forced to 0.
  - Otherwise: ertn_flush = ws_ertn, csr_we = ws_csr_we, rf_we = ws_rf_we.
- Redirect: on an exc or ertn commit, latch flush_pc (ex_entry if exc, else ertn_pc, both sampled in the commit cycle) and go to FLUSH.
- ws_flush = (commit && (exc || ertn_flush)) || state==FLUSH.
- FLUSH: flush_valid=1 and flush_pc is held stable. On flush_valid && flush_ready, return to NORMAL next cycle. ms data presented in the handshake cycle is still dropped.
- Outputs that are not strobes (wb_pc, csr_num, data) reflect the WB register. All strobes are 0 when ws_valid=0 or state==FLUSH.

## Timing
- Reset values: ws_valid=0, state=NORMAL. All strobes, flush_valid and ws_flush are 0. flush_pc=0.
- Latency: MEM→WB register is 1 cycle. Strobes are combinational from the WB register in the commit cycle.
- flush_valid rises the cycle after the commit. Minimum FLUSH residency is 1 cycle when flush_ready is already high.
- has_int and an instruction exception in the same cycle: INT wins and ERA receives ws_pc.
- ERTN carrying an exception flag: the exception wins and ertn_flush=0.
- Reset asserted during FLUSH: next cycle NORMAL, flush_valid=0, redirect abandoned.

## Configuration
- WB_DEBUG_TRACE_EN
  - Defined: adds outputs debug_wb_pc[31:0], debug_wb_rf_we[3:0] = {4{rf_we}}, debug_wb_rf_wnum[4:0] and debug_wb_rf_wdata[31:0] for the golden-trace comparator. All are 0 on reset.
  - Undefined: these ports and their logic are absent.

## Structure
- Shared header (alongside the existing CSR defines): ECODE_INT/ADE/ALE/SYS/BRK/INE, ESUBCODE_ADEF/ADEM, EXC_VEC_* bit indices, state encoding.
- One sub-module: exc_prio_enc, combinational. Takes the vector plus int_tag and outputs exc, ecode, esubcode and use_vaddr.

## Test plan
- Plain ADD commit, rf_we=1, waddr=5, wdata=0x1234: next cycle rf_we=1, waddr=5, wdata=0x1234, wb_ex=0, no flush.
- SYSCALL at pc 0x1c000100 with ex_entry=0x1c008000: wb_ex=1, ecode=0xB, rf_we=0; then flush_valid=1 with flush_pc=0x1c008000, held while flush_ready=0 for 3 cycles.
- ALE with vaddr 0x8000_0003 and INE also set: ecode=0xD (INE wins), wb_vaddr=pc. With only ALE set: ecode=0x9, wb_vaddr=0x8000_0003.
- ERTN with ertn_pc=0x1c000200: ertn_flush=1, wb_ex=0, flush_pc=0x1c000200. Back-to-back ms_valid during FLUSH produces no rf_we.
- has_int=1 on a CSRWR commit: wb_ex=1, ecode=0, csr_we=0, wb_pc=instruction pc.
- Reset in the 2nd FLUSH cycle: flush_valid=0 the next cycle; the following instruction commits normally.
